// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_stage
// Description : Two-entry registered skid buffer for a fetch/decode pipeline
//               boundary, with flush and a saturating count of flushed entries.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_stage #(
    parameter int                 DATA_W     = 64,
    parameter logic [DATA_W-1:0]  BUBBLE_VAL = DATA_W'(64'h0000_0000_0000_0013),
    parameter int                 CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [1:0]        level,
    output logic [CNT_W-1:0]  drop_cnt
);

    // State encoding doubles as the occupancy reported on level.
    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
    localparam logic [1:0] c_FULL  = 2'd2;

    localparam logic [CNT_W+1:0] c_CNT_MAX = {2'b00, {CNT_W{1'b1}}};

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [CNT_W-1:0]  r_drop_cnt;

    logic              w_accept;
    logic              w_send;
    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] w_main_nxt;
    logic [DATA_W-1:0] w_skid_nxt;
    logic [2:0]        w_drop_inc;
    logic [CNT_W+1:0]  w_drop_sum;
    logic [CNT_W-1:0]  w_drop_nxt;

    assign w_accept = in_valid & r_in_ready;
    assign w_send   = r_out_valid & out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = c_EMPTY;
            w_main_nxt  = BUBBLE_VAL;
            w_skid_nxt  = BUBBLE_VAL;
        end else begin
            case (r_state)
                c_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = c_ONE;
                        w_main_nxt  = in_data;
                    end
                end
                c_ONE: begin
                    if (w_accept && w_send) begin
                        w_main_nxt = in_data;
                    end else if (w_accept) begin
                        w_state_nxt = c_FULL;
                        w_skid_nxt  = in_data;
                    end else if (w_send) begin
                        w_state_nxt = c_EMPTY;
                        w_main_nxt  = BUBBLE_VAL;
                    end
                end
                c_FULL: begin
                    if (w_send) begin
                        w_state_nxt = c_ONE;
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = BUBBLE_VAL;
                    end
                end
                default: begin
                    w_state_nxt = c_EMPTY;
                    w_main_nxt  = BUBBLE_VAL;
                    w_skid_nxt  = BUBBLE_VAL;
                end
            endcase
        end
    end

    // Entries lost to a flush: those held, plus one arriving, minus one leaving.
    always_comb begin
        w_drop_inc = 3'({1'b0, r_state}) + 3'(w_accept) - 3'(w_send);
        w_drop_sum = {2'b00, r_drop_cnt} + (CNT_W+2)'(w_drop_inc);
        if (w_drop_sum > c_CNT_MAX) begin
            w_drop_nxt = {CNT_W{1'b1}};
        end else begin
            w_drop_nxt = w_drop_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_EMPTY;
            r_main      <= BUBBLE_VAL;
            r_skid      <= BUBBLE_VAL;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_main      <= w_main_nxt;
            r_skid      <= w_skid_nxt;
            r_in_ready  <= (w_state_nxt != c_FULL);
            r_out_valid <= (w_state_nxt != c_EMPTY);
            if (flush) begin
                r_drop_cnt <= w_drop_nxt;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;
    assign level     = r_state;
    assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire
